parity_frame_tx_ctrl: RTL and testbench

//   Sequencer that wraps the 4-bit even-parity function into a serial framed transmitter.

---
 rtl/parity_frame_tx_ctrl.sv | 82 ++++++++
 tb/tb_parity_frame_tx_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/parity_frame_tx_ctrl.sv
// parity_frame_tx_ctrl: framed serial transmitter sending start, LSB-first data, parity and stop bits
module parity_frame_tx_ctrl #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_out,
  output logic              frame_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic par_n, tx_n, wrap, accept;
  // Outputs are registered from the next-state values so tx lines up with the state it belongs to
  always_comb begin
    accept = in_valid && in_ready;
    wrap = cnt == CNT_LAST;
    state_n = state;
    cnt_n = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    par_n = parity_out;
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        shift_n = in_data;
        par_n = (^in_data) ^ 1'(ODD_PARITY);
      end
      START: if (wrap) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (wrap) begin
        if (bit_idx == BIT_LAST) state_n = PARITY;
        else begin
          bit_n = bit_idx + 1'b1;
          shift_n = shift >> 1;
        end
      end
      PARITY: if (wrap) state_n = STOP;
      STOP: if (wrap) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      in_ready <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
      in_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      frame_done <= state == STOP && state_n == IDLE;
      parity_out <= par_n;
    end
  end
endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// tb_parity_frame_tx_ctrl: randomized directed bench against a per-cycle frame model
module tb_parity_frame_tx_ctrl;
  localparam int CPB = 4;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, tx, busy, parity_out, frame_done;
  logic [3:0] in_data = '0;
  logic o_valid = 0, o_ready, o_tx, o_busy, o_parity, o_done;
  logic [3:0] o_data = '0;
  int checks = 0, errors = 0;

  parity_frame_tx_ctrl #(.DATA_W(4), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx(tx), .busy(busy), .parity_out(parity_out), .frame_done(frame_done));

  parity_frame_tx_ctrl #(.DATA_W(4), .CLKS_PER_BIT(1), .ODD_PARITY(1)) odd (
    .clk(clk), .rst(rst), .in_valid(o_valid), .in_data(o_data), .in_ready(o_ready),
    .tx(o_tx), .busy(o_busy), .parity_out(o_parity), .frame_done(o_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole frame as one bit per clock: start, data LSB first, parity, stop
  function automatic void build(input logic [3:0] d, input int cpb, input bit odd_p,
                                output logic q[$], output logic p);
    p = 1'(($countones(d) % 2) != 0) ^ odd_p;
    q = {};
    for (int k = 0; k < cpb; k++) q.push_back(1'b0);
    for (int b = 0; b < 4; b++) for (int k = 0; k < cpb; k++) q.push_back(d[b]);
    for (int k = 0; k < cpb; k++) q.push_back(p);
    for (int k = 0; k < cpb; k++) q.push_back(1'b1);
  endfunction

  task automatic frame(input logic [3:0] d, input bit pre, input bit chain, input logic [3:0] nxt);
    logic q[$];
    logic p;
    build(d, CPB, 1'b0, q, p);
    if (!pre) begin
      @(negedge clk);
      chk("idle_ready", 8'(in_ready), 8'd1);
      chk("idle_done", 8'(frame_done), 8'd0);
      in_valid = 1;
      in_data = d;
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d] d=%0h", i, d), 8'(tx), 8'(q[i]));
      chk("busy", 8'(busy), 8'd1);
      chk("ready_busy", 8'(in_ready), 8'd0);
      chk("done_busy", 8'(frame_done), 8'd0);
      chk("parity_out", 8'(parity_out), 8'(p));
      in_valid = chain ? 1'b1 : (i < q.size() - 1 ? 1'($urandom) : 1'b0);
      in_data = (chain && i == q.size() - 1) ? nxt : 4'($urandom);
    end
    @(negedge clk);
    chk("done_pulse", 8'(frame_done), 8'd1);
    chk("done_tx", 8'(tx), 8'd1);
    chk("done_ready", 8'(in_ready), 8'd1);
    chk("done_busy0", 8'(busy), 8'd0);
  endtask

  initial begin
    logic q[$];
    logic p;
    in_valid = 1;
    in_data = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      chk("rst_tx", 8'(tx), 8'd1);
      chk("rst_ready", 8'(in_ready), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(frame_done), 8'd0);
      chk("rst_parity", 8'(parity_out), 8'd0);
    end
    rst = 0;
    in_valid = 0;
    frame(4'b0001, 0, 0, 4'b0);
    chk("t2_parity", 8'(parity_out), 8'd1);
    @(negedge clk);
    chk("t2_single_pulse", 8'(frame_done), 8'd0);
    for (int w = 0; w < 8; w++) frame(4'(w), 0, 0, 4'b0);
    repeat (4) frame(4'($urandom), 0, 0, 4'b0);
    frame(4'b0011, 0, 1, 4'b0100);
    frame(4'b0100, 1, 0, 4'b0);
    in_valid = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = 4'b0110;
    build(4'b0110, CPB, 1'b0, q, p);
    for (int i = 0; i <= 3 * CPB; i++) begin
      @(negedge clk);
      in_valid = 0;
      chk("abort_tx", 8'(tx), 8'(q[i]));
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_tx1", 8'(tx), 8'd1);
    chk("abort_ready", 8'(in_ready), 8'd1);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(frame_done), 8'd0);
    repeat (3 * CPB) begin
      @(negedge clk);
      chk("abort_no_done", 8'(frame_done), 8'd0);
      chk("abort_idle_tx", 8'(tx), 8'd1);
    end
    frame(4'b0101, 0, 0, 4'b0);
    @(negedge clk);
    o_valid = 1;
    o_data = 4'b0000;
    build(4'b0000, 1, 1'b1, q, p);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      o_valid = 0;
      chk($sformatf("odd_tx[%0d]", i), 8'(o_tx), 8'(q[i]));
      chk("odd_busy", 8'(o_busy), 8'd1);
      chk("odd_parity", 8'(o_parity), 8'(p));
    end
    @(negedge clk);
    chk("odd_done", 8'(o_done), 8'd1);
    chk("odd_busy0", 8'(o_busy), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
